// File: rtl/state_machine.sv
// -----------------------------------------------------------------------------
// state_machine
//   Three independent sensor-to-buzzer alarm channels.  Each channel debounces
//   its sensor (DEBOUNCE consecutive high samples arm the alarm), drives a
//   square-wave buzzer while alarmed (half-period HALFn cycles), and keeps
//   sounding through a cooldown window of COOLDOWN low samples before
//   returning to idle.  A high sample during cooldown resumes the alarm
//   without re-debouncing and without restarting the buzzer waveform.
//
// Parameters
//   DEBOUNCE  consecutive high samples needed to raise an alarm   (1-15)
//   COOLDOWN  cycles spent in cooldown before an alarm stops       (1-15)
//   HALF1..3  buzzer half-period in cycles for channels 1..3        (1-15)
//
// Ports
//   clk                 rising-edge clock for all state
//   reset               asynchronous, active-high reset
//   sensor1..sensor3    synchronous sensor levels (already in clk domain)
//   buzzer1..buzzer3    registered buzzer drive, one per channel
// -----------------------------------------------------------------------------
module state_machine #(
  parameter int DEBOUNCE = 3,
  parameter int COOLDOWN = 4,
  parameter int HALF1    = 1,
  parameter int HALF2    = 2,
  parameter int HALF3    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor1,
  input  logic sensor2,
  input  logic sensor3,
  output logic buzzer1,
  output logic buzzer2,
  output logic buzzer3
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARM      = 2'd1,
    ST_ALARM    = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  // Count value held in ARM just before the arming sample arrives.
  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 1);
  // Number of cooldown cycles; the low sample that finds the count already
  // at this value is the one that ends the alarm, so the channel spends
  // exactly COOLDOWN cycles in cooldown.
  localparam logic [3:0] COOL_N   = 4'(COOLDOWN);

  logic [2:0] sensor_vec;
  logic [2:0] buzzer_vec;

  assign sensor_vec = {sensor3, sensor2, sensor1};
  assign buzzer1    = buzzer_vec[0];
  assign buzzer2    = buzzer_vec[1];
  assign buzzer3    = buzzer_vec[2];

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    // Phase value at which the buzzer flips for this channel.
    localparam logic [3:0] PHASE_LAST =
      4'(((gi == 0) ? HALF1 : (gi == 1) ? HALF2 : HALF3) - 1);

    state_t     state_reg;
    logic [3:0] count_reg;
    logic [3:0] phase_reg;
    logic       buzzer_reg;

    logic       sensor;
    logic       phase_wrap;
    logic [3:0] phase_next;
    logic       buzzer_next;
    logic [3:0] count_next;

    assign sensor = sensor_vec[gi];

    // Free-running buzzer waveform used in both ALARM and COOLDOWN so the
    // pattern never restarts when the channel moves between those states.
    assign phase_wrap  = (phase_reg >= PHASE_LAST);
    assign phase_next  = phase_wrap ? 4'd0 : phase_reg + 4'd1;
    assign buzzer_next = phase_wrap ? ~buzzer_reg : buzzer_reg;

    // Event counter saturates rather than wrapping.
    assign count_next  = (count_reg == 4'hF) ? count_reg : count_reg + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_reg  <= ST_IDLE;
        count_reg  <= 4'd0;
        phase_reg  <= 4'd0;
        buzzer_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (sensor) begin
              if (DEBOUNCE <= 1) begin
                // Single-sample debounce: alarm straight away.
                state_reg  <= ST_ALARM;
                count_reg  <= 4'd0;
                phase_reg  <= 4'd0;
                buzzer_reg <= 1'b1;
              end else begin
                state_reg  <= ST_ARM;
                count_reg  <= 4'd1;
              end
            end
          end

          ST_ARM: begin
            if (!sensor) begin
              state_reg <= ST_IDLE;
              count_reg <= 4'd0;
            end else if (count_reg >= DEB_LAST) begin
              // This sample is the DEBOUNCE-th consecutive high one.
              state_reg  <= ST_ALARM;
              count_reg  <= 4'd0;
              phase_reg  <= 4'd0;
              buzzer_reg <= 1'b1;
            end else begin
              count_reg <= count_next;
            end
          end

          ST_ALARM: begin
            phase_reg  <= phase_next;
            buzzer_reg <= buzzer_next;
            if (!sensor) begin
              state_reg <= ST_COOLDOWN;
              count_reg <= 4'd1;
            end
          end

          ST_COOLDOWN: begin
            if (sensor) begin
              // Resume alarm; waveform carries on untouched.
              state_reg  <= ST_ALARM;
              count_reg  <= 4'd0;
              phase_reg  <= phase_next;
              buzzer_reg <= buzzer_next;
            end else if (count_reg >= COOL_N) begin
              state_reg  <= ST_IDLE;
              count_reg  <= 4'd0;
              phase_reg  <= 4'd0;
              buzzer_reg <= 1'b0;
            end else begin
              count_reg  <= count_next;
              phase_reg  <= phase_next;
              buzzer_reg <= buzzer_next;
            end
          end

          default: begin
            state_reg  <= ST_IDLE;
            count_reg  <= 4'd0;
            phase_reg  <= 4'd0;
            buzzer_reg <= 1'b0;
          end
        endcase
      end
    end

    assign buzzer_vec[gi] = buzzer_reg;
  end

endmodule

// File: tb/tb_state_machine.sv
// -----------------------------------------------------------------------------
// tb_state_machine
//   Self-checking bench for state_machine with default parameters.  Directed
//   scenarios compare against literal expected sequences; a randomized run
//   compares every cycle against a behavioural model that describes each
//   channel as "alarm active or not" plus run lengths of high/low samples and
//   the number of cycles elapsed since the alarm began.
// -----------------------------------------------------------------------------
module tb_state_machine;

  localparam int DEB  = 3;
  localparam int COOL = 4;

  logic clk = 1'b0;
  logic reset;
  logic sensor1 = 1'b0;
  logic sensor2 = 1'b0;
  logic sensor3 = 1'b0;
  logic buzzer1;
  logic buzzer2;
  logic buzzer3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  state_machine #(
    .DEBOUNCE(DEB),
    .COOLDOWN(COOL),
    .HALF1(1),
    .HALF2(2),
    .HALF3(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sensor1(sensor1),
    .sensor2(sensor2),
    .sensor3(sensor3),
    .buzzer1(buzzer1),
    .buzzer2(buzzer2),
    .buzzer3(buzzer3)
  );

  // ---------------- behavioural reference model ----------------
  int m_half [3] = '{1, 2, 4};
  int m_high [3];   // consecutive high samples while not alarmed
  int m_low  [3];   // consecutive low samples while alarmed
  int m_k    [3];   // cycles since the alarm started
  bit m_act  [3];   // alarm (including cooldown) in progress
  bit m_buz  [3];

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) begin
      m_high[c] = 0;
      m_low[c]  = 0;
      m_k[c]    = 0;
      m_act[c]  = 1'b0;
      m_buz[c]  = 1'b0;
    end
  endfunction

  function automatic void model_step(int c, bit s);
    if (!m_act[c]) begin
      if (s) begin
        m_high[c]++;
        if (m_high[c] >= DEB) begin
          m_act[c] = 1'b1;
          m_k[c]   = 0;
          m_low[c] = 0;
        end
      end else begin
        m_high[c] = 0;
      end
    end else begin
      m_k[c]++;
      if (s) begin
        m_low[c] = 0;
      end else begin
        m_low[c]++;
        // Alarm keeps sounding for COOL low cycles; the next low ends it.
        if (m_low[c] > COOL) begin
          m_act[c]  = 1'b0;
          m_high[c] = 0;
        end
      end
    end
    m_buz[c] = m_act[c] && (((m_k[c] / m_half[c]) % 2) == 0);
  endfunction

  // Drive one cycle of sensor levels; returns 1 time unit after the edge.
  task automatic tick(input logic s1, input logic s2, input logic s3);
    sensor1 = s1;
    sensor2 = s2;
    sensor3 = s3;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      model_step(0, s1);
      model_step(1, s2);
      model_step(2, s3);
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({buzzer1, buzzer2, buzzer3} !== 3'b000) begin
      failures++;
      $display("FAIL reset_no_clock: buzzers=%b required 000", {buzzer1, buzzer2, buzzer3});
    end
    #2;
    reset = 1'b0;   // released before the first rising edge
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if ({buzzer1, buzzer2, buzzer3} !== 3'b000) begin
        failures++;
        $display("FAIL reset_release step %0d: buzzers=%b required 000", i, {buzzer1, buzzer2, buzzer3});
      end
      $display("test_reset step=%0d buzzers=%b", i, {buzzer1, buzzer2, buzzer3});
    end
  endtask

  task automatic test_ch1_alarm();
    bit exp1 [16];
    exp1 = '{0,0,1,0,1,0,1,0,1,0, 1,0,1,0, 0,0};
    for (int i = 0; i < 16; i++) begin
      tick(i < 10, 1'b0, 1'b0);
      checks++;
      if (buzzer1 !== exp1[i]) begin
        failures++;
        $display("FAIL ch1_alarm step %0d: buzzer1=%b required %b", i, buzzer1, exp1[i]);
      end
      checks++;
      if ({buzzer2, buzzer3} !== 2'b00) begin
        failures++;
        $display("FAIL ch1_isolation step %0d: buzzer2/3=%b required 00", i, {buzzer2, buzzer3});
      end
      $display("test_ch1_alarm step=%0d s1=%0d buzzers=%b", i, i < 10, {buzzer1, buzzer2, buzzer3});
    end
  endtask

  task automatic test_short_pulse();
    // Two-edge pulse on sensor2, then single-edge pulses on every channel.
    for (int i = 0; i < 16; i++) begin
      logic s2p;
      logic sp;
      s2p = (i < 2);
      sp  = (i >= 6) && (i % 2 == 0);
      tick(sp, s2p | sp, sp);
      checks++;
      if ({buzzer1, buzzer2, buzzer3} !== 3'b000) begin
        failures++;
        $display("FAIL short_pulse step %0d: buzzers=%b required 000", i, {buzzer1, buzzer2, buzzer3});
      end
      $display("test_short_pulse step=%0d buzzers=%b", i, {buzzer1, buzzer2, buzzer3});
    end
  endtask

  task automatic test_ch3_alarm();
    bit exp3 [16];
    exp3 = '{0,0,1,1,1,1,0,0,0,0, 1,1,1,1, 0,0};
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b0, i < 10);
      checks++;
      if (buzzer3 !== exp3[i]) begin
        failures++;
        $display("FAIL ch3_alarm step %0d: buzzer3=%b required %b", i, buzzer3, exp3[i]);
      end
      checks++;
      if ({buzzer1, buzzer2} !== 2'b00) begin
        failures++;
        $display("FAIL ch3_isolation step %0d: buzzer1/2=%b required 00", i, {buzzer1, buzzer2});
      end
      $display("test_ch3_alarm step=%0d s3=%0d buzzers=%b", i, i < 10, {buzzer1, buzzer2, buzzer3});
    end
  endtask

  task automatic test_dual();
    for (int n = 1; n <= 40; n++) begin
      logic e2;
      logic e3;
      tick(1'b0, 1'b1, 1'b1);
      e2 = (n >= 3) && ((((n - 3) / 2) % 2) == 0);
      e3 = (n >= 3) && ((((n - 3) / 4) % 2) == 0);
      checks++;
      if ({buzzer1, buzzer2, buzzer3} !== {1'b0, e2, e3}) begin
        failures++;
        $display("FAIL dual edge %0d: buzzers=%b required %b", n, {buzzer1, buzzer2, buzzer3}, {1'b0, e2, e3});
      end
      $display("test_dual edge=%0d buzzers=%b", n, {buzzer1, buzzer2, buzzer3});
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if ({buzzer1, buzzer2, buzzer3} !== {m_buz[0], m_buz[1], m_buz[2]}) begin
        failures++;
        $display("FAIL dual_cooldown step %0d: buzzers=%b required %b", i, {buzzer1, buzzer2, buzzer3}, {m_buz[0], m_buz[1], m_buz[2]});
      end
      $display("test_dual cooldown step=%0d buzzers=%b", i, {buzzer1, buzzer2, buzzer3});
    end
  endtask

  task automatic test_drop_and_reset();
    bit exp1 [17];
    exp1 = '{0,0,1,0,1,0,1,0, 1,0, 1,0,1,0,1,0, 1};
    for (int i = 0; i < 17; i++) begin
      tick((i < 8) || (i >= 10), 1'b0, 1'b0);
      checks++;
      if (buzzer1 !== exp1[i]) begin
        failures++;
        $display("FAIL drop_resume step %0d: buzzer1=%b required %b", i, buzzer1, exp1[i]);
      end
      $display("test_drop step=%0d buzzer1=%b", i, buzzer1);
    end
    // Assert reset between edges while buzzer1 is high.
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({buzzer1, buzzer2, buzzer3} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_alarm: buzzers=%b required 000", {buzzer1, buzzer2, buzzer3});
    end
    $display("test_reset_mid_alarm buzzers=%b", {buzzer1, buzzer2, buzzer3});
    // Sensor activity while reset held is ignored.
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      checks++;
      if ({buzzer1, buzzer2, buzzer3} !== 3'b000) begin
        failures++;
        $display("FAIL reset_held step %0d: buzzers=%b required 000", i, {buzzer1, buzzer2, buzzer3});
      end
    end
    #2;
    reset = 1'b0;
    // First edge after release samples normally: alarm on the third edge.
    for (int i = 0; i < 3; i++) begin
      logic e;
      tick(1'b1, 1'b1, 1'b1);
      e = (i == 2);
      checks++;
      if ({buzzer1, buzzer2, buzzer3} !== {e, e, e}) begin
        failures++;
        $display("FAIL post_reset step %0d: buzzers=%b required %b", i, {buzzer1, buzzer2, buzzer3}, {e, e, e});
      end
      $display("test_post_reset step=%0d buzzers=%b", i, {buzzer1, buzzer2, buzzer3});
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    // Re-arm immediately after each alarm ends, with varying gap lengths.
    for (int i = 0; i < 40; i++) begin
      logic s;
      s = ((i % 13) < 5);
      tick(s, ~s, s);
      checks++;
      if ({buzzer1, buzzer2, buzzer3} !== {m_buz[0], m_buz[1], m_buz[2]}) begin
        failures++;
        $display("FAIL back_to_back step %0d: buzzers=%b required %b", i, {buzzer1, buzzer2, buzzer3}, {m_buz[0], m_buz[1], m_buz[2]});
      end
      $display("test_back_to_back step=%0d buzzers=%b", i, {buzzer1, buzzer2, buzzer3});
    end
  endtask

  task automatic test_random();
    int run [3];
    bit lvl [3];
    for (int c = 0; c < 3; c++) begin
      run[c] = 0;
      lvl[c] = 1'b0;
    end
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (run[c] == 0) begin
          lvl[c] = 1'($urandom_range(0, 1));
          run[c] = int'($urandom_range(1, 10));
        end
        run[c]--;
      end
      tick(lvl[0], lvl[1], lvl[2]);
      checks++;
      if ({buzzer1, buzzer2, buzzer3} !== {m_buz[0], m_buz[1], m_buz[2]}) begin
        failures++;
        $display("FAIL random cycle %0d: buzzers=%b required %b", i, {buzzer1, buzzer2, buzzer3}, {m_buz[0], m_buz[1], m_buz[2]});
      end
      $display("test_random cycle=%0d sensors=%b buzzers=%b", i, {lvl[0], lvl[1], lvl[2]}, {buzzer1, buzzer2, buzzer3});
    end
  endtask

  initial begin
    test_reset();
    test_ch1_alarm();
    test_short_pulse();
    test_ch3_alarm();
    test_dual();
    test_drop_and_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
